// File: rtl/riscv_mem_pkg.sv
// Shared types for the unified-memory port arbiter.
// State and owner encodings plus default widths.
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_D = 2'd1,
        GNT_I = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    localparam int ADDR_W_DEF        = 64;
    localparam int DATA_W_DEF        = 64;
    localparam int INSTR_W_DEF       = 32;
    localparam int TIMEOUT_DEF       = 16;
    localparam int IF_STARVE_MAX_DEF = 4;

endpackage

// File: rtl/mem_watchdog.sv
// Transaction watchdog: counts enabled cycles, flags expiry.
// Holds at TIMEOUT until cleared.
module mem_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    assign expired = (cnt == CW'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (enable && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory port between IF fetch and MEM load/store.
// Data has priority; a starvation counter forces fetch through.
module mem_port_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W        = ADDR_W_DEF,
    parameter int DATA_W        = DATA_W_DEF,
    parameter int INSTR_W       = INSTR_W_DEF,
    parameter int TIMEOUT       = TIMEOUT_DEF,
    parameter int IF_STARVE_MAX = IF_STARVE_MAX_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               if_req,
    input  logic [ADDR_W-1:0]  if_addr,
    output logic [INSTR_W-1:0] if_rdata,
    output logic               if_done,
    input  logic               d_req,
    input  logic               d_we,
    input  logic [ADDR_W-1:0]  d_addr,
    input  logic [DATA_W-1:0]  d_wdata,
    output logic [DATA_W-1:0]  d_rdata,
    output logic               d_done,
    output logic               mem_req,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic [DATA_W-1:0]  mem_rdata,
    input  logic               mem_ack,
    output logic               stall,
    output logic               timeout_err
);

    localparam int SW = $clog2(IF_STARVE_MAX + 1);

    arb_state_e    state;
    owner_e        owner;
    logic [SW-1:0] starve_cnt;
    logic          in_gnt;
    logic          expired;
    logic          starve_full;
    logic          fetch_wins;

    assign in_gnt      = (state == GNT_D) || (state == GNT_I);
    assign owner       = (state == GNT_I) ? OWN_I : OWN_D;
    assign starve_full = (starve_cnt == SW'(IF_STARVE_MAX));
    assign fetch_wins  = if_req && (!d_req || starve_full);
    assign stall       = (if_req & ~if_done) | (d_req & ~d_done);

    mem_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_wdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (!in_gnt),
        .enable (in_gnt),
        .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            if_rdata    <= '0;
            d_rdata     <= '0;
            if_done     <= 1'b0;
            d_done      <= 1'b0;
            starve_cnt  <= '0;
            timeout_err <= 1'b0;
        end else begin
            if_done <= 1'b0;
            d_done  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (fetch_wins) begin
                        state      <= GNT_I;
                        mem_req    <= 1'b1;
                        mem_we     <= 1'b0;
                        mem_addr   <= if_addr;
                        mem_wdata  <= '0;
                        starve_cnt <= '0;
                    end else if (d_req) begin
                        state     <= GNT_D;
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        if (if_req && !starve_full) begin
                            starve_cnt <= starve_cnt + 1'b1;
                        end
                    end
                end
                GNT_D, GNT_I: begin
                    // A same-cycle ack beats watchdog expiry.
                    if (mem_ack || expired) begin
                        state   <= RESP;
                        mem_req <= 1'b0;
                        if (!mem_ack) begin
                            timeout_err <= 1'b1;
                        end
                        if (owner == OWN_I) begin
                            if_done  <= 1'b1;
                            if_rdata <= mem_ack ? mem_rdata[INSTR_W-1:0] : '0;
                        end else begin
                            d_done  <= 1'b1;
                            d_rdata <= (mem_ack && !mem_we) ? mem_rdata : '0;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed cases then
// random traffic against a queue/array reference model.
module tb_mem_port_arbiter;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int IW = 32;
    localparam int TO = 16;
    localparam int SM = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [IW-1:0] if_rdata;
    logic          if_done;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_done;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          stall;
    logic          timeout_err;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .INSTR_W(IW),
        .TIMEOUT(TO), .IF_STARVE_MAX(SM)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr),
        .if_rdata(if_rdata), .if_done(if_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_done(d_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .stall(stall),
        .timeout_err(timeout_err)
    );

    int n_checks = 0;
    int n_fail   = 0;
    // -1: never ack, -2: random 0..3, else cycles before ack
    int ack_delay = 0;
    bit force_ack = 0;

    logic [63:0] ref_mem [logic [63:0]];
    logic [63:0] dev_mem [logic [63:0]];
    logic [IW-1:0] if_q [$];
    logic [DW-1:0] d_q [$];

    function automatic logic [63:0] init_val(input logic [63:0] a);
        return (a * 64'h9E37_79B9_7F4A_7C15) ^ 64'h0F0F_1234_5678_9ABC;
    endfunction

    function automatic logic [63:0] ref_rd(input logic [63:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    function automatic logic [63:0] dev_rd(input logic [63:0] a);
        return dev_mem.exists(a) ? dev_mem[a] : init_val(a);
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mem_model();
        int wait_n = -1;
        bit busy = 0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            if (force_ack) begin
                mem_ack   = 1'b1;
                mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
                force_ack = 0;
            end else if (mem_req && !reset) begin
                if (!busy) begin
                    busy = 1;
                    wait_n = (ack_delay == -2) ? int'($urandom_range(0, 3))
                                               : ack_delay;
                end
                if (wait_n == 0) begin
                    mem_ack   = 1'b1;
                    mem_rdata = dev_rd(mem_addr);
                    if (mem_we) dev_mem[mem_addr] = mem_wdata;
                    busy = 0;
                end else if (wait_n > 0) begin
                    wait_n--;
                end
            end else begin
                busy = 0;
                mem_rdata = {$urandom, $urandom};
            end
        end
    endtask

    task automatic monitor();
        bit p_if = 0;
        bit p_d = 0;
        bit p_mreq = 0;
        int starve = 0;
        bit fw;
        forever begin
            @(posedge clk);
            #2;
            if (reset) begin
                if_q.delete();
                d_q.delete();
                starve = 0;
                p_if = 0;
                p_d = 0;
                p_mreq = 0;
            end else begin
                check("stall", 64'(stall),
                      64'((if_req & ~if_done) | (d_req & ~d_done)));
                check("done_exclusive", 64'(if_done & d_done), 64'd0);
                if (if_done) begin
                    if (if_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL if_done_spurious: got pulse, none expected");
                    end else begin
                        check("if_rdata", 64'(if_rdata), 64'(if_q.pop_front()));
                    end
                end
                if (d_done) begin
                    if (d_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL d_done_spurious: got pulse, none expected");
                    end else begin
                        check("d_rdata", d_rdata, d_q.pop_front());
                    end
                end
                if (mem_req && !p_mreq) begin
                    if (!p_if && !p_d) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL grant_spurious: mem_req rose, no request");
                    end else begin
                        fw = p_if && (!p_d || starve == SM);
                        if (fw) begin
                            check("grant_i_addr", mem_addr, if_addr);
                            check("grant_i_we", 64'(mem_we), 64'd0);
                            starve = 0;
                        end else begin
                            check("grant_d_addr", mem_addr, d_addr);
                            check("grant_d_we", 64'(mem_we), 64'(d_we));
                            if (d_we) check("grant_d_wdata", mem_wdata, d_wdata);
                            if (p_if) starve = (starve < SM) ? starve + 1 : SM;
                        end
                    end
                end
                p_if = if_req;
                p_d = d_req;
                p_mreq = mem_req;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        if_req = 0; if_addr = '0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_req"}, 64'(mem_req), 64'd0);
        check({tag, "_mem_we"}, 64'(mem_we), 64'd0);
        check({tag, "_mem_addr"}, mem_addr, 64'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 64'd0);
        check({tag, "_if_done"}, 64'(if_done), 64'd0);
        check({tag, "_d_done"}, 64'(d_done), 64'd0);
        check({tag, "_if_rdata"}, 64'(if_rdata), 64'd0);
        check({tag, "_d_rdata"}, d_rdata, 64'd0);
        check({tag, "_timeout_err"}, 64'(timeout_err), 64'd0);
    endtask

    // Returns cycles from request drive to done pulse, -1 on no response.
    task automatic if_txn(input logic [63:0] a, output int lat);
        logic [63:0] v;
        v = ref_rd(a);
        if_req = 1'b1;
        if_addr = a;
        if_q.push_back(v[IW-1:0]);
        lat = -1;
        for (int c = 1; c <= 200; c++) begin
            tick();
            if (if_done) begin
                lat = c;
                break;
            end
        end
        if_req = 1'b0;
        if (lat < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL if_txn_hang: no if_done in 200 cycles, addr %h", a);
        end
    endtask

    task automatic d_txn(input bit we, input logic [63:0] a,
                         input logic [63:0] w, input bit exp_to,
                         output int lat);
        d_req = 1'b1;
        d_we = we;
        d_addr = a;
        d_wdata = w;
        if (exp_to || we) d_q.push_back('0);
        else d_q.push_back(ref_rd(a));
        if (we && !exp_to) ref_mem[a] = w;
        lat = -1;
        for (int c = 1; c <= 200; c++) begin
            tick();
            if (d_done) begin
                lat = c;
                break;
            end
        end
        d_req = 1'b0;
        d_we = 1'b0;
        if (lat < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL d_txn_hang: no d_done in 200 cycles, addr %h", a);
        end
    endtask

    task automatic if_agent(input int n);
        int lat;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            if_txn(64'h1000 + 64'(8 * $urandom_range(0, 31)), lat);
        end
    endtask

    task automatic d_agent(input int n);
        int lat;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            d_txn(1'($urandom_range(0, 1)),
                  64'(8 * $urandom_range(0, 31)),
                  {$urandom, $urandom}, 1'b0, lat);
        end
    endtask

    initial begin
        int lat, d_at, i_at, nd, ni, nm, n_before;
        bit got_if;
        reset = 1'b1;
        if_req = 0; if_addr = '0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        dev_mem[64'h40] = 64'h1234_5678_0050_0093;
        ref_mem[64'h40] = 64'h1234_5678_0050_0093;
        fork
            mem_model();
            monitor();
            begin
                repeat (20000) @(posedge clk);
                $display("FAIL global_timeout: run exceeded 20000 cycles");
                $fatal(1);
            end
        join_none

        do_reset();
        check_reset_outputs("reset");

        // Fetch only, ack one cycle after mem_req rises
        ack_delay = 1;
        if_req = 1'b1;
        if_addr = 64'h40;
        if_q.push_back(32'h0050_0093);
        tick();
        check("t1_mem_req", 64'(mem_req), 64'd1);
        check("t1_mem_addr", mem_addr, 64'h40);
        tick();
        check("t1_if_done_early", 64'(if_done), 64'd0);
        tick();
        check("t1_if_done", 64'(if_done), 64'd1);
        check("t1_if_rdata", 64'(if_rdata), 64'h0050_0093);
        check("t1_stall", 64'(stall), 64'd0);
        if_req = 1'b0;
        tick();
        check("t1_if_done_pulse", 64'(if_done), 64'd0);

        // Collision: data first, then fetch
        ack_delay = 0;
        if_req = 1'b1; if_addr = 64'h40;
        if_q.push_back(32'h0050_0093);
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h100;
        d_q.push_back(ref_rd(64'h100));
        d_at = -1; i_at = -1; nd = 0; ni = 0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (d_done) begin
                nd++;
                if (d_at < 0) d_at = c;
                d_req = 1'b0;
            end
            if (if_done) begin
                ni++;
                if (i_at < 0) i_at = c;
                if_req = 1'b0;
            end
        end
        check("t2_d_done_cycle", 64'(d_at), 64'd2);
        check("t2_if_done_cycle", 64'(i_at), 64'd5);
        check("t2_d_done_count", 64'(nd), 64'd1);
        check("t2_if_done_count", 64'(ni), 64'd1);

        // Starvation: fetch forced through after SM data wins
        if_req = 1'b1; if_addr = 64'h48;
        begin
            logic [63:0] v;
            v = ref_rd(64'h48);
            if_q.push_back(v[IW-1:0]);
        end
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h0;
        d_q.push_back(ref_rd(64'h0));
        got_if = 0; n_before = 0; nd = 0;
        for (int c = 0; c < 80; c++) begin
            tick();
            if (if_done) begin
                got_if = 1;
                if_req = 1'b0;
            end
            if (d_done) begin
                nd++;
                if (!got_if) begin
                    n_before++;
                    d_addr = d_addr + 64'h8;
                    d_q.push_back(ref_rd(d_addr));
                end else begin
                    d_req = 1'b0;
                end
            end
            if (got_if && !d_req) break;
        end
        check("t3_data_before_fetch", 64'(n_before), 64'(SM));
        check("t3_fetch_served", 64'(got_if), 64'd1);
        check("t3_total_data", 64'(nd), 64'(SM + 1));
        tick();

        // Store, then read it back
        d_txn(1'b1, 64'h200, 64'hDEAD_BEEF, 1'b0, lat);
        check("t4_store_lat", 64'(lat), 64'd2);
        check("t4_store_rdata", d_rdata, 64'd0);
        tick();
        d_txn(1'b0, 64'h200, 64'd0, 1'b0, lat);
        check("t4_load_back", d_rdata, 64'hDEAD_BEEF);
        tick();

        // Watchdog expiry without ack
        ack_delay = -1;
        d_txn(1'b0, 64'h300, 64'd0, 1'b1, lat);
        check("t5_timeout_lat", 64'(lat), 64'd18);
        check("t5_timeout_err", 64'(timeout_err), 64'd1);
        tick();
        ack_delay = 0;
        if_txn(64'h1008, lat);
        check("t5_fetch_after_to", 64'(lat), 64'd2);
        check("t5_err_sticky", 64'(timeout_err), 64'd1);

        // Ack exactly in the expiry cycle
        do_reset();
        ack_delay = TO;
        d_txn(1'b0, 64'h308, 64'd0, 1'b0, lat);
        check("t5b_ack_at_expiry_lat", 64'(lat), 64'd18);
        check("t5b_no_error", 64'(timeout_err), 64'd0);
        tick();

        // Reset during fetch grant
        ack_delay = -1;
        if_req = 1'b1; if_addr = 64'h58;
        if_q.push_back(32'h0);
        tick();
        check("t6_mem_req", 64'(mem_req), 64'd1);
        tick();
        reset = 1'b1;
        if_req = 1'b0;
        tick();
        reset = 1'b0;
        check_reset_outputs("t6");
        force_ack = 1;
        ni = 0; nm = 0;
        repeat (6) begin
            tick();
            ni += int'(if_done);
            nm += int'(mem_req);
        end
        check("t6_no_if_done", 64'(ni), 64'd0);
        check("t6_no_mem_req", 64'(nm), 64'd0);

        // Random concurrent traffic
        do_reset();
        ack_delay = -2;
        fork
            if_agent(60);
            d_agent(60);
        join
        repeat (4) tick();
        check("if_q_drained", 64'(if_q.size()), 64'd0);
        check("d_q_drained", 64'(d_q.size()), 64'd0);
        check("rand_no_error", 64'(timeout_err), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
